// File: rtl/trigger_sequencer_of_verifla_pkg.sv
// Shared constants for the VeriFLA trigger sequencer:
// FSM state codes, stage count and the per-stage slice helper.
package trigger_sequencer_of_verifla_pkg;

  localparam int NUM_STAGES = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TRIG = 2'd2;

  // LSB position of stage k inside a packed
  // per-stage bus of w-bit fields.
  function automatic int slice_lo(
    input int k,
    input int w
  );
    return k * w;
  endfunction

endpackage

// File: rtl/trigger_sequencer_of_verifla_divider.sv
// Sample decimator: q is high when div_cnt is 0, then
// the counter reloads to div; load forces div_cnt to 0.
// Ports: clk, rst (async high), load, div -> q.
module sample_divider_of_verifla #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             q
);

  logic [DIV_W-1:0] r_cnt;

  assign q = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= '0;
    end else if (q) begin
      r_cnt <= div;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/trigger_sequencer_of_verifla.sv
// Multi-stage trigger sequencer + decimator feeding the
// logic-analyzer core (data_in, cqual, exttrig).
// Ports: probe_in, arm/abort pulses, packed per-stage
// cfg_value/cfg_mask/cfg_count, cfg_last, cfg_div;
// outputs data_out, cqual, exttrig, stage, busy.
module trigger_sequencer_of_verifla
  import trigger_sequencer_of_verifla_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            probe_in,
  input  logic                         arm,
  input  logic                         abort,
  input  logic [NUM_STAGES*DATA_W-1:0] cfg_value,
  input  logic [NUM_STAGES*DATA_W-1:0] cfg_mask,
  input  logic [NUM_STAGES*CNT_W-1:0]  cfg_count,
  input  logic [1:0]                   cfg_last,
  input  logic [DIV_W-1:0]             cfg_div,
  output logic [DATA_W-1:0]            data_out,
  output logic                         cqual,
  output logic                         exttrig,
  output logic [1:0]                   stage,
  output logic                         busy
);

  logic [NUM_STAGES*DATA_W-1:0] r_value;
  logic [NUM_STAGES*DATA_W-1:0] r_mask;
  logic [NUM_STAGES*CNT_W-1:0]  r_count;
  logic [1:0]                   r_last;
  logic [DIV_W-1:0]             r_div;

  logic [1:0]        r_state;
  logic [1:0]        r_stage;
  logic [CNT_W-1:0]  r_occ;
  logic [DATA_W-1:0] r_data;
  logic              r_cqual;

  logic              w_load;
  logic              w_q;
  logic              w_hit;
  logic [DATA_W-1:0] w_val;
  logic [DATA_W-1:0] w_msk;
  logic [CNT_W-1:0]  w_cnt;

  // abort wins over a simultaneous arm
  assign w_load = arm & ~abort;

  sample_divider_of_verifla #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .load(w_load),
    .div (r_div),
    .q   (w_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
      r_mask  <= '0;
      r_count <= '0;
      r_last  <= '0;
      r_div   <= '0;
    end else if (w_load) begin
      r_value <= cfg_value;
      r_mask  <= cfg_mask;
      r_count <= cfg_count;
      r_last  <= cfg_last;
      r_div   <= cfg_div;
    end
  end

  assign w_val =
    r_value[slice_lo(int'(r_stage), DATA_W) +: DATA_W];
  assign w_msk =
    r_mask[slice_lo(int'(r_stage), DATA_W) +: DATA_W];
  assign w_cnt =
    r_count[slice_lo(int'(r_stage), CNT_W) +: CNT_W];

  assign w_hit = (((probe_in ^ w_val) & w_msk) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_stage <= '0;
      r_occ   <= '0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_stage <= '0;
      r_occ   <= '0;
    end else if (arm) begin
      r_state <= ST_RUN;
      r_stage <= '0;
      r_occ   <= '0;
    end else begin
      unique case (1'b1)
        (r_state == ST_RUN): begin
          if (w_q && w_hit) begin
            if (r_occ == w_cnt) begin
              r_occ <= '0;
              if (r_stage == r_last) begin
                r_state <= ST_TRIG;
              end else begin
                r_stage <= r_stage + 1'b1;
              end
            end else begin
              r_occ <= r_occ + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data and strobe registered in the same edge as the
  // FSM, so exttrig lines up with its triggering sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_cqual <= 1'b0;
    end else begin
      r_data  <= probe_in;
      r_cqual <= w_q;
    end
  end

  assign data_out = r_data;
  assign cqual    = r_cqual;
  assign exttrig  = (r_state == ST_TRIG);
  assign busy     = (r_state == ST_RUN);
  assign stage    = r_stage;

endmodule

// File: tb/tb_trigger_sequencer_of_verifla.sv
// Randomized bench for trigger_sequencer_of_verifla
// against a cycle-level behavioural model.
module tb_trigger_sequencer_of_verifla;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] probe_in;
  logic          arm;
  logic          abort;
  logic [4*DW-1:0] cfg_value;
  logic [4*DW-1:0] cfg_mask;
  logic [4*CW-1:0] cfg_count;
  logic [1:0]      cfg_last;
  logic [VW-1:0]   cfg_div;
  logic [DW-1:0]   data_out;
  logic            cqual;
  logic            exttrig;
  logic [1:0]      stage;
  logic            busy;

  trigger_sequencer_of_verifla #(
    .DATA_W(DW),
    .CNT_W (CW),
    .DIV_W (VW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .probe_in (probe_in),
    .arm      (arm),
    .abort    (abort),
    .cfg_value(cfg_value),
    .cfg_mask (cfg_mask),
    .cfg_count(cfg_count),
    .cfg_last (cfg_last),
    .cfg_div  (cfg_div),
    .data_out (data_out),
    .cqual    (cqual),
    .exttrig  (exttrig),
    .stage    (stage),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_trig = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Model: mode 0=idle 1=run 2=triggered
  int       m_mode;
  int       m_stage;
  int       m_occ;
  int       m_dcnt;
  bit [7:0] s_val [4];
  bit [7:0] s_msk [4];
  int       s_cnt [4];
  int       s_last;
  int       s_div;
  bit [7:0] e_data;
  bit       e_cqual;

  task automatic m_reset();
    m_mode  = 0;
    m_stage = 0;
    m_occ   = 0;
    m_dcnt  = 0;
    s_last  = 0;
    s_div   = 0;
    e_data  = 0;
    e_cqual = 0;
    for (int k = 0; k < 4; k++) begin
      s_val[k] = 0;
      s_msk[k] = 0;
      s_cnt[k] = 0;
    end
  endtask

  // One clock of behaviour, using the inputs now applied.
  task automatic m_step();
    bit q;
    bit hit;
    q = (m_dcnt == 0);
    e_data  = probe_in;
    e_cqual = q;
    if (arm && !abort) m_dcnt = 0;
    else if (q) m_dcnt = s_div;
    else m_dcnt = m_dcnt - 1;
    hit = ((probe_in ^ s_val[m_stage])
           & s_msk[m_stage]) == 8'h00;
    if (abort) begin
      m_mode = 0; m_stage = 0; m_occ = 0;
    end else if (arm) begin
      for (int k = 0; k < 4; k++) begin
        s_val[k] = cfg_value[k*DW +: DW];
        s_msk[k] = cfg_mask[k*DW +: DW];
        s_cnt[k] = int'(cfg_count[k*CW +: CW]);
      end
      s_last = int'(cfg_last);
      s_div  = int'(cfg_div);
      m_mode = 1; m_stage = 0; m_occ = 0;
    end else if (m_mode == 1 && q && hit) begin
      if (m_occ < s_cnt[m_stage]) begin
        m_occ++;
      end else begin
        m_occ = 0;
        if (m_stage == s_last) begin
          m_mode = 2;
          n_trig++;
        end else begin
          m_stage++;
        end
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".data"},  32'(data_out), 32'(e_data));
    chk({tag, ".cqual"}, 32'(cqual),    32'(e_cqual));
    chk({tag, ".trig"},  32'(exttrig),  32'(m_mode == 2));
    chk({tag, ".busy"},  32'(busy),     32'(m_mode == 1));
    chk({tag, ".stage"}, 32'(stage),    32'(m_stage));
  endtask

  task automatic cycle(input string tag);
    if (rst) m_reset();
    else m_step();
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  task automatic rand_cfg();
    cfg_value = $urandom();
    cfg_mask  = $urandom() | $urandom();
    for (int k = 0; k < 4; k++)
      cfg_count[k*CW +: CW] = CW'($urandom_range(0, 3));
    cfg_last = 2'($urandom_range(0, 3));
    cfg_div  = VW'($urandom_range(0, 3));
  endtask

  initial begin
    rst = 1'b1;
    probe_in = '0;
    arm = 1'b0;
    abort = 1'b0;
    cfg_value = '0;
    cfg_mask  = '0;
    cfg_count = '0;
    cfg_last  = '0;
    cfg_div   = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    rst = 1'b0;

    // Single stage A5, exact match, no decimation
    cfg_value = 32'h0000_00A5;
    cfg_mask  = 32'h0000_00FF;
    arm = 1'b1;
    cycle("a5_arm");
    arm = 1'b0;
    for (int i = 1; i < 10; i++) cycle("a5_wait");
    probe_in = 8'hA5;
    cycle("a5_hit");
    chk("a5_trig", 32'(exttrig), 32'd1);
    chk("a5_data", 32'(data_out), 32'hA5);
    probe_in = 8'h00;
    cycle("a5_hold");

    // Same-cycle arm+abort
    arm = 1'b1;
    cycle("rearm");
    abort = 1'b1;
    cycle("armabort");
    chk("armabort_busy", 32'(busy), 32'd0);
    arm = 1'b0;
    abort = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      if (i % 25 == 0) rand_cfg();
      arm   = ($urandom_range(0, 59) == 0);
      abort = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) < 6)
        probe_in = s_val[m_stage];
      else
        probe_in = DW'($urandom());
      if (i == 1500) begin
        rst = 1'b1;
        #1;
        m_reset();
        check_outs("async_rst");
        cycle("in_rst");
        rst = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
      end
      cycle("rand");
    end

    chk("trig_seen", 32'(n_trig > 2), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
